// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-fill memory port between the icache (read only) and the
// dcache (read or write-back). It grants round-robin, registers the memory request, returns
// the line and the fault flag to the winner, and aborts a stalled transfer with a watchdog.
module mem_line_arbiter #(
    parameter int unsigned LINE_BITS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_BITS       = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_addr_i,
    input  logic                 i_rd_i,
    output logic [LINE_BITS-1:0] i_data_o,
    output logic                 i_ack_o,
    output logic                 i_fault_o,
    input  logic [31:0]          d_addr_i,
    input  logic                 d_rd_i,
    input  logic                 d_wr_i,
    input  logic [LINE_BITS-1:0] d_wdata_i,
    output logic [LINE_BITS-1:0] d_data_o,
    output logic                 d_ack_o,
    output logic                 d_fault_o,
    output logic [31:0]          m_addr_o,
    output logic                 m_rd_o,
    output logic                 m_wr_o,
    output logic [LINE_BITS-1:0] m_wdata_o,
    input  logic [LINE_BITS-1:0] m_data_i,
    input  logic                 m_ack_i,
    input  logic                 m_fault_i,
    output logic                 busy_o
);

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    // Watchdog fires on the last allowed MEM cycle; a zero timeout disables it.
    localparam logic [CNT_BITS-1:0] WdLast   = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam bit                  WdEnable = (TIMEOUT_CYCLES != 0);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_sel_d;   // current transfer belongs to the dcache
    logic                r_last_d;  // last grant went to the dcache
    logic [CNT_BITS-1:0] r_wd;

    logic w_d_req;
    logic w_req_any;
    logic w_grant_d;
    logic w_timeout;
    logic w_done;

    assign w_d_req   = d_rd_i | d_wr_i;
    assign w_req_any = i_rd_i | w_d_req;
    // D wins when it is the only requester, or on a tie when I had the last grant.
    assign w_grant_d = w_d_req & (~i_rd_i | ~r_last_d);
    // A memory ack in the same cycle takes priority over the timeout.
    assign w_timeout = WdEnable && (r_state == StMem) && (r_wd == WdLast) && !m_ack_i;
    assign w_done    = (r_state == StMem) && (m_ack_i || w_timeout);
    assign busy_o    = (r_state != StIdle);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> MEM on any request, MEM -> RESP on ack/timeout, RESP -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_req_any) w_state_next = StMem;
            StMem:   if (w_done) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Grant latch, memory request registers, watchdog and response routing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_d   <= 1'b0;
            r_last_d  <= 1'b1;
            r_wd      <= '0;
            m_addr_o  <= '0;
            m_rd_o    <= 1'b0;
            m_wr_o    <= 1'b0;
            m_wdata_o <= '0;
            i_data_o  <= '0;
            i_ack_o   <= 1'b0;
            i_fault_o <= 1'b0;
            d_data_o  <= '0;
            d_ack_o   <= 1'b0;
            d_fault_o <= 1'b0;
        end else begin
            i_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_req_any) begin
                        r_sel_d  <= w_grant_d;
                        r_last_d <= w_grant_d;
                        r_wd     <= '0;
                        m_addr_o <= w_grant_d ? d_addr_i : i_addr_i;
                        if (w_grant_d && d_wr_i) begin
                            m_wr_o    <= 1'b1;
                            m_wdata_o <= d_wdata_i;
                        end else begin
                            m_rd_o <= 1'b1;
                        end
                    end
                end
                StMem: begin
                    r_wd <= r_wd + CNT_BITS'(1);
                    if (w_done) begin
                        m_rd_o <= 1'b0;
                        m_wr_o <= 1'b0;
                        if (r_sel_d) begin
                            d_ack_o   <= 1'b1;
                            d_data_o  <= m_ack_i ? m_data_i : '0;
                            d_fault_o <= m_ack_i ? m_fault_i : 1'b1;
                        end else begin
                            i_ack_o   <= 1'b1;
                            i_data_o  <= m_ack_i ? m_data_i : '0;
                            i_fault_o <= m_ack_i ? m_fault_i : 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
